// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: shared constants and types for the MII transmitter.
// Register offsets, STATUS bits, FSM states, CRC and framing constants.
package eth_tx_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_LEN    = 2'd2;
  localparam logic [1:0] REG_DATA   = 2'd3;

  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_EMPTY = 3;
  localparam int ST_OVF   = 4;
  localparam int ST_URUN  = 5;
  localparam int ST_CNT   = 16;

  localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [10:0] MIN_FRAME = 11'd60;
  localparam logic [15:0] PRE_NIB   = 16'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IFG
  } state_t;

endpackage

// File: rtl/eth_tx_mmio_crc32_d4.sv
// crc32_d4: next reflected CRC-32 after one 4-bit input.
// Bits are consumed LSB first.
module crc32_d4
  import eth_tx_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [3:0]  i_d,
  output logic [31:0] o_crc
);

  always_comb begin
    logic [31:0] c;
    c = i_crc;
    for (int k = 0; k < 4; k++) begin
      c = (c >> 1) ^ ((c[0] ^ i_d[k]) ? CRC_POLY : 32'h0);
    end
    o_crc = c;
  end

endmodule

// File: rtl/eth_tx_mmio.sv
// eth_tx_mmio: memory-mapped MII Ethernet transmitter.
// Word FIFO feeds a nibble FSM that adds preamble, pad and FCS.
module eth_tx_mmio
  import eth_tx_pkg::*;
#(
  parameter logic [31:0] BASE    = 32'h1001_0000,
  parameter int          FIFO_AW = 9,
  parameter bit          PAD_EN  = 1'b1,
  parameter int          IFG_NIB = 24
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        dm_cs,
  input  logic        dm_r,
  input  logic        dm_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        tx_ce,
  output logic [3:0]  mii_txd,
  output logic        mii_tx_en,
  output logic        irq
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic w_sel, w_wr;
  logic [1:0] w_reg;
  logic w_ctrl_wr, w_stat_wr, w_len_wr, w_data_wr;
  logic w_unused;

  assign w_sel     = dm_cs & (addr[31:4] == BASE[31:4]);
  assign w_wr      = w_sel & dm_w;
  assign w_reg     = addr[3:2];
  assign w_ctrl_wr = w_wr & (w_reg == REG_CTRL);
  assign w_stat_wr = w_wr & (w_reg == REG_STATUS);
  assign w_len_wr  = w_wr & (w_reg == REG_LEN);
  assign w_data_wr = w_wr & (w_reg == REG_DATA);
  assign w_unused  = ^addr[1:0];

  logic [31:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0]   r_count;
  logic w_full, w_empty, w_push, w_pop;
  logic [31:0] w_rd_word;

  // count never exceeds DEPTH, so its MSB alone means full
  assign w_full    = r_count[FIFO_AW];
  assign w_empty   = (r_count == '0);
  assign w_push    = w_data_wr & ~w_full;
  assign w_rd_word = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  logic        r_busy, r_done, r_ovf, r_urun, r_irq_en;
  logic [10:0] r_len;
  logic        w_urun_set, w_done_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_urun   <= 1'b0;
      r_irq_en <= 1'b0;
      r_len    <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_irq_en <= wdata[1];
        if (wdata[0] && !r_busy && r_len != '0) begin
          r_busy <= 1'b1;
          r_done <= 1'b0;
        end
      end
      if (w_stat_wr) begin
        if (wdata[ST_DONE]) r_done <= 1'b0;
        if (wdata[ST_OVF])  r_ovf  <= 1'b0;
        if (wdata[ST_URUN]) r_urun <= 1'b0;
      end
      if (w_len_wr && !r_busy) r_len <= wdata[10:0];
      if (w_data_wr && w_full) r_ovf <= 1'b1;
      if (w_urun_set) r_urun <= 1'b1;
      // hardware set takes priority over a same-cycle W1C
      if (w_done_set) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  state_t      r_state, w_state_n;
  logic [15:0] r_cnt, w_cnt_n;
  logic [10:0] r_bcnt, w_bcnt_n, w_bcnt_inc;
  logic        r_hi, w_hi_n;
  logic [31:0] r_crc, w_crc_n, w_crc_upd, w_crc_inv;
  logic [31:0] r_word, w_word_n;
  logic [7:0]  r_byte, w_byte_n, w_lane_byte;
  logic [3:0]  r_txd, w_txd_n, w_nib, w_fcs_nib;
  logic        r_txen, w_txen_n;

  assign w_bcnt_inc = r_bcnt + 11'd1;
  assign w_crc_inv  = ~r_crc;
  assign w_fcs_nib  = w_crc_inv[{r_cnt[2:0], 2'b00} +: 4];

  always_comb begin
    case (r_bcnt[1:0])
      2'd0:    w_lane_byte = w_rd_word[7:0];
      2'd1:    w_lane_byte = r_word[15:8];
      2'd2:    w_lane_byte = r_word[23:16];
      default: w_lane_byte = r_word[31:24];
    endcase
  end

  always_comb begin
    w_nib = 4'h0;
    if (r_state == S_DATA) w_nib = r_hi ? r_byte[7:4] : w_lane_byte[3:0];
  end

  crc32_d4 u_crc (
    .i_crc (r_crc),
    .i_d   (w_nib),
    .o_crc (w_crc_upd)
  );

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_bcnt_n   = r_bcnt;
    w_hi_n     = r_hi;
    w_crc_n    = r_crc;
    w_word_n   = r_word;
    w_byte_n   = r_byte;
    w_txd_n    = r_txd;
    w_txen_n   = r_txen;
    w_pop      = 1'b0;
    w_urun_set = 1'b0;
    w_done_set = 1'b0;
    if (tx_ce) begin
      unique case (r_state)
        S_IDLE: begin
          w_txd_n  = 4'h0;
          w_txen_n = 1'b0;
          if (r_busy) begin
            w_state_n = S_PRE;
            w_cnt_n   = '0;
          end
        end
        S_PRE: begin
          w_txd_n  = 4'h5;
          w_txen_n = 1'b1;
          w_cnt_n  = r_cnt + 16'd1;
          if (r_cnt == PRE_NIB - 16'd1) w_state_n = S_SFD;
        end
        S_SFD: begin
          w_txd_n   = 4'hD;
          w_txen_n  = 1'b1;
          w_crc_n   = CRC_INIT;
          w_bcnt_n  = '0;
          w_hi_n    = 1'b0;
          w_state_n = S_DATA;
        end
        S_DATA: begin
          if (!r_hi && r_bcnt[1:0] == 2'd0 && w_empty) begin
            w_urun_set = 1'b1;
            w_txd_n    = 4'h0;
            w_txen_n   = 1'b0;
            w_cnt_n    = '0;
            w_state_n  = S_IFG;
          end else begin
            w_txd_n  = w_nib;
            w_txen_n = 1'b1;
            w_crc_n  = w_crc_upd;
            w_hi_n   = ~r_hi;
            if (!r_hi) begin
              w_byte_n = w_lane_byte;
              if (r_bcnt[1:0] == 2'd0) begin
                w_pop    = 1'b1;
                w_word_n = w_rd_word;
              end
            end else begin
              w_bcnt_n = w_bcnt_inc;
              if (w_bcnt_inc == r_len) begin
                w_cnt_n   = '0;
                w_state_n = (PAD_EN && r_len < MIN_FRAME) ? S_PAD : S_FCS;
              end
            end
          end
        end
        S_PAD: begin
          w_txd_n  = w_nib;
          w_txen_n = 1'b1;
          w_crc_n  = w_crc_upd;
          w_hi_n   = ~r_hi;
          if (r_hi) begin
            w_bcnt_n = w_bcnt_inc;
            if (w_bcnt_inc == MIN_FRAME) begin
              w_cnt_n   = '0;
              w_state_n = S_FCS;
            end
          end
        end
        S_FCS: begin
          w_txd_n  = w_fcs_nib;
          w_txen_n = 1'b1;
          w_cnt_n  = r_cnt + 16'd1;
          if (r_cnt[2:0] == 3'd7) begin
            w_cnt_n   = '0;
            w_state_n = S_IFG;
          end
        end
        S_IFG: begin
          w_txd_n  = 4'h0;
          w_txen_n = 1'b0;
          w_cnt_n  = r_cnt + 16'd1;
          if (r_cnt == 16'(IFG_NIB - 1)) begin
            w_done_set = 1'b1;
            w_state_n  = S_IDLE;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_hi    <= 1'b0;
      r_crc   <= CRC_INIT;
      r_word  <= '0;
      r_byte  <= '0;
      r_txd   <= '0;
      r_txen  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bcnt  <= w_bcnt_n;
      r_hi    <= w_hi_n;
      r_crc   <= w_crc_n;
      r_word  <= w_word_n;
      r_byte  <= w_byte_n;
      r_txd   <= w_txd_n;
      r_txen  <= w_txen_n;
    end
  end

  logic [31:0] w_status;

  always_comb begin
    w_status           = '0;
    w_status[ST_BUSY]  = r_busy;
    w_status[ST_DONE]  = r_done;
    w_status[ST_FULL]  = w_full;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_OVF]   = r_ovf;
    w_status[ST_URUN]  = r_urun;
    w_status[ST_CNT +: FIFO_AW + 1] = r_count;
  end

  always_comb begin
    rdata = '0;
    if (w_sel && dm_r) begin
      case (w_reg)
        REG_CTRL:   rdata = {30'b0, r_irq_en, 1'b0};
        REG_STATUS: rdata = w_status;
        REG_LEN:    rdata = {21'b0, r_len};
        default:    rdata = '0;
      endcase
    end
  end

  assign mii_txd   = r_txd;
  assign mii_tx_en = r_txen;
  assign irq       = r_done & r_irq_en;

endmodule

// File: tb/tb_eth_tx_mmio.sv
// tb_eth_tx_mmio: scoreboard bench for the MII transmitter.
// Expected nibbles are queued with stimulus and matched against captures.
module tb_eth_tx_mmio;
  import eth_tx_pkg::*;

  localparam logic [31:0] BASE = 32'h1001_0000;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs_a = 1'b0, cs_b = 1'b0;
  logic        dm_r = 1'b0, dm_w = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        tx_ce = 1'b0;
  logic [31:0] rdata_a, rdata_b;
  logic [3:0]  txd_a, txd_b;
  logic        en_a, en_b, irq_a, irq_b;

  int   n_vec = 0;
  int   n_err = 0;
  bit   ce_en = 1'b1;
  int   div = 0;
  bit   mon_b = 1'b0;
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];

  always #5 clk = ~clk;

  eth_tx_mmio u_pad (
    .clk(clk), .rst(rst), .dm_cs(cs_a), .dm_r(dm_r), .dm_w(dm_w),
    .addr(addr), .wdata(wdata), .rdata(rdata_a), .tx_ce(tx_ce),
    .mii_txd(txd_a), .mii_tx_en(en_a), .irq(irq_a)
  );

  eth_tx_mmio #(.PAD_EN(1'b0)) u_nopad (
    .clk(clk), .rst(rst), .dm_cs(cs_b), .dm_r(dm_r), .dm_w(dm_w),
    .addr(addr), .wdata(wdata), .rdata(rdata_b), .tx_ce(tx_ce),
    .mii_txd(txd_b), .mii_tx_en(en_b), .irq(irq_b)
  );

  function automatic logic [31:0] fcs_of(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c ^= {24'h0, b[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (tx_ce && (mon_b ? en_b : en_a))
      got_q.push_back(mon_b ? txd_b : txd_a);
    tx_ce = ce_en && (div == 3);
    div = (div + 1) % 4;
  endtask

  task automatic wr(input bit d, input logic [3:0] off, input logic [31:0] v);
    cs_a = !d;
    cs_b = d;
    dm_w = 1'b1;
    addr = BASE + {28'h0, off};
    wdata = v;
    step();
    cs_a = 1'b0;
    cs_b = 1'b0;
    dm_w = 1'b0;
  endtask

  task automatic rd(input bit d, input logic [3:0] off, output logic [31:0] v);
    cs_a = !d;
    cs_b = d;
    dm_r = 1'b1;
    addr = BASE + {28'h0, off};
    #1;
    v = d ? rdata_b : rdata_a;
    cs_a = 1'b0;
    cs_b = 1'b0;
    dm_r = 1'b0;
  endtask

  task automatic run_frame(input bit d, input int budget, output bit to);
    logic [31:0] s;
    to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      step();
      rd(d, 4'h4, s);
      if (s[ST_DONE]) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic push_hdr();
    repeat (15) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
  endtask

  task automatic push_bytes(input bq_t b);
    foreach (b[i]) begin
      exp_q.push_back(b[i][3:0]);
      exp_q.push_back(b[i][7:4]);
    end
  endtask

  task automatic push_fcs(input logic [31:0] f);
    for (int k = 0; k < 8; k++) exp_q.push_back(f[4*k +: 4]);
  endtask

  task automatic test_reset();
    logic [31:0] s;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    n_vec++;
    if ({en_a, txd_a, irq_a, en_b, txd_b, irq_b} !== 12'h0) begin
      n_err++;
      $display("FAIL rst_outs got %h want 000", {en_a, txd_a, irq_a, en_b, txd_b, irq_b});
    end
    rd(0, 4'h4, s);
    n_vec++;
    if (s !== 32'h8) begin
      n_err++;
      $display("FAIL rst_status got %h want 00000008", s);
    end
    rd(0, 4'h8, s);
    n_vec++;
    if (s !== 32'h0) begin
      n_err++;
      $display("FAIL rst_len got %h want 0", s);
    end
    rd(0, 4'h0, s);
    n_vec++;
    if (s !== 32'h0) begin
      n_err++;
      $display("FAIL rst_ctrl got %h want 0", s);
    end
  endtask

  task automatic test_nopad_frame();
    bq_t b, f;
    logic [31:0] s;
    logic [3:0] e, g;
    bit to;
    mon_b = 1'b1;
    exp_q.delete();
    got_q.delete();
    wr(1, 4'hC, 32'h3433_3231);
    wr(1, 4'hC, 32'h3837_3635);
    wr(1, 4'hC, 32'h0000_0039);
    wr(1, 4'h8, 32'd9);
    b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    f = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    push_hdr();
    push_bytes(b);
    push_bytes(f);
    wr(1, 4'h0, 32'h1);
    run_frame(1, 3000, to);
    n_vec++;
    if (to) begin
      n_err++;
      $display("FAIL t1_timeout got busy want done");
    end
    n_vec++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL t1_nibcount got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL t1_nib got %h want %h", g, e);
      end
    end
    rd(1, 4'h4, s);
    n_vec++;
    if (s[1:0] !== 2'b10) begin
      n_err++;
      $display("FAIL t1_status got %b want 10", s[1:0]);
    end
  endtask

  task automatic test_pad_irq();
    bq_t b;
    logic [31:0] s;
    logic [3:0] e, g;
    bit to;
    mon_b = 1'b0;
    exp_q.delete();
    got_q.delete();
    wr(0, 4'h8, 32'd1);
    wr(0, 4'hC, 32'h0000_00AB);
    b.push_back(8'hAB);
    repeat (59) b.push_back(8'h00);
    push_hdr();
    push_bytes(b);
    push_fcs(fcs_of(b));
    wr(0, 4'h0, 32'h3);
    run_frame(0, 4000, to);
    n_vec++;
    if (to) begin
      n_err++;
      $display("FAIL t2_timeout got busy want done");
    end
    n_vec++;
    if (got_q.size() !== 144) begin
      n_err++;
      $display("FAIL t2_txen_nibs got %0d want 144", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL t2_nib got %h want %h", g, e);
      end
    end
    n_vec++;
    if (irq_a !== 1'b1) begin
      n_err++;
      $display("FAIL t2_irq_set got %b want 1", irq_a);
    end
    wr(0, 4'h4, 32'h2);
    n_vec++;
    if (irq_a !== 1'b0) begin
      n_err++;
      $display("FAIL t2_irq_clr got %b want 0", irq_a);
    end
    rd(0, 4'h4, s);
    n_vec++;
    if (s[ST_DONE] !== 1'b0) begin
      n_err++;
      $display("FAIL t2_done_w1c got %b want 0", s[ST_DONE]);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] s;
    for (int i = 0; i < 513; i++) wr(0, 4'hC, i);
    rd(0, 4'h4, s);
    n_vec++;
    if ({s[25:16], s[ST_OVF], s[ST_EMPTY], s[ST_FULL]} !== {10'd512, 3'b101}) begin
      n_err++;
      $display("FAIL t3_full got cnt=%0d ovf=%b empty=%b full=%b want cnt=512 ovf=1 empty=0 full=1",
               s[25:16], s[ST_OVF], s[ST_EMPTY], s[ST_FULL]);
    end
    wr(0, 4'h4, 32'h10);
    rd(0, 4'h4, s);
    n_vec++;
    if ({s[ST_OVF], s[ST_FULL]} !== 2'b01) begin
      n_err++;
      $display("FAIL t3_ovf_w1c got ovf=%b full=%b want ovf=0 full=1", s[ST_OVF], s[ST_FULL]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_underrun();
    bq_t b;
    logic [31:0] s;
    logic [3:0] e, g;
    bit to;
    mon_b = 1'b0;
    exp_q.delete();
    got_q.delete();
    wr(0, 4'h8, 32'd8);
    wr(0, 4'hC, 32'h4433_2211);
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_hdr();
    push_bytes(b);
    wr(0, 4'h0, 32'h1);
    run_frame(0, 3000, to);
    n_vec++;
    if (to) begin
      n_err++;
      $display("FAIL t4_timeout got busy want done");
    end
    n_vec++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL t4_nibcount got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL t4_nib got %h want %h", g, e);
      end
    end
    rd(0, 4'h4, s);
    n_vec++;
    if ({s[ST_URUN], s[ST_DONE], s[ST_BUSY], irq_a} !== 4'b1100) begin
      n_err++;
      $display("FAIL t4_urun got urun=%b done=%b busy=%b irq=%b want 1100",
               s[ST_URUN], s[ST_DONE], s[ST_BUSY], irq_a);
    end
    wr(0, 4'h4, 32'h22);
    rd(0, 4'h4, s);
    n_vec++;
    if ({s[ST_URUN], s[ST_DONE]} !== 2'b00) begin
      n_err++;
      $display("FAIL t4_w1c got urun=%b done=%b want 00", s[ST_URUN], s[ST_DONE]);
    end
  endtask

  task automatic test_start_rules();
    bq_t b;
    logic [31:0] s;
    logic [3:0] e, g;
    bit to;
    mon_b = 1'b0;
    exp_q.delete();
    got_q.delete();
    ce_en = 1'b0;
    step();
    wr(0, 4'h8, 32'd4);
    wr(0, 4'hC, 32'hDDCC_BBAA);
    wr(0, 4'h0, 32'h1);
    wr(0, 4'h8, 32'd10);
    wr(0, 4'h0, 32'h1);
    rd(0, 4'h8, s);
    n_vec++;
    if (s !== 32'd4) begin
      n_err++;
      $display("FAIL t5_len_busy got %h want 4", s);
    end
    rd(0, 4'h4, s);
    n_vec++;
    if (s !== 32'h0001_0001) begin
      n_err++;
      $display("FAIL t5_status got %h want 00010001", s);
    end
    rd(0, 4'h0, s);
    n_vec++;
    if (s !== 32'h0) begin
      n_err++;
      $display("FAIL t5_ctrl got %h want 0", s);
    end
    cs_a = 1'b1;
    dm_r = 1'b1;
    addr = BASE + 32'h10;
    #1;
    n_vec++;
    if (rdata_a !== 32'h0) begin
      n_err++;
      $display("FAIL t5_unsel got %h want 0", rdata_a);
    end
    dm_r = 1'b0;
    addr = BASE + 32'h4;
    #1;
    n_vec++;
    if (rdata_a !== 32'h0) begin
      n_err++;
      $display("FAIL t5_noread got %h want 0", rdata_a);
    end
    cs_a = 1'b0;
    ce_en = 1'b1;
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    repeat (56) b.push_back(8'h00);
    push_hdr();
    push_bytes(b);
    push_fcs(fcs_of(b));
    run_frame(0, 4000, to);
    n_vec++;
    if (to) begin
      n_err++;
      $display("FAIL t5_timeout got busy want done");
    end
    n_vec++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL t5_nibcount got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL t5_nib got %h want %h", g, e);
      end
    end
    got_q.delete();
    repeat (400) step();
    n_vec++;
    if (got_q.size() !== 0) begin
      n_err++;
      $display("FAIL t5_second_frame got %0d nibbles want 0", got_q.size());
    end
    wr(0, 4'h8, 32'd0);
    wr(0, 4'h0, 32'h1);
    rd(0, 4'h4, s);
    n_vec++;
    if (s[1:0] !== 2'b10) begin
      n_err++;
      $display("FAIL t5_len0_start got %b want 10", s[1:0]);
    end
    rd(0, 4'h8, s);
    n_vec++;
    if (s !== 32'h0) begin
      n_err++;
      $display("FAIL t5_len0 got %h want 0", s);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] s;
    bit reached;
    mon_b = 1'b0;
    got_q.delete();
    reached = 1'b0;
    wr(0, 4'h8, 32'd8);
    wr(0, 4'hC, 32'h0403_0201);
    wr(0, 4'hC, 32'h0807_0605);
    wr(0, 4'h0, 32'h1);
    for (int c = 0; c < 2000; c++) begin
      step();
      if (got_q.size() >= 18) begin
        reached = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!reached) begin
      n_err++;
      $display("FAIL t6_reach_data got %0d nibbles want 18", got_q.size());
    end
    n_vec++;
    if (en_a !== 1'b1) begin
      n_err++;
      $display("FAIL t6_pre_en got %b want 1", en_a);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (en_a !== 1'b0) begin
      n_err++;
      $display("FAIL t6_en_drop got %b want 0", en_a);
    end
    rd(0, 4'h4, s);
    n_vec++;
    if (s[ST_BUSY] !== 1'b0) begin
      n_err++;
      $display("FAIL t6_busy got %b want 0", s[ST_BUSY]);
    end
    step();
    rst = 1'b0;
    step();
    rd(0, 4'h4, s);
    n_vec++;
    if (s !== 32'h8) begin
      n_err++;
      $display("FAIL t6_empty got %h want 00000008", s);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_nopad_frame();
    test_pad_irq();
    test_overflow();
    test_underrun();
    test_start_rules();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
